// File: rtl/sort_fifo.sv
// sort_fifo: batch-sorting FIFO.
// Words are collected in FILL until a batch is closed (eop or capacity reached).
// The batch is then sorted in place by odd-even transposition over N cycles
// (SORT), and drained in sorted order through a showahead head word (DRAIN).
//
// Ports:
//   clk_i          clock, rising edge
//   srst_i         asynchronous active-high reset
//   data_i         write word (unsigned)
//   wrreq_i        write request (FILL only)
//   eop_i          end of batch
//   rdreq_i        read request, pops head (DRAIN only)
//   q_o            head word of the sorted batch (holds last value when empty)
//   empty_o        no readable word
//   full_o         write not accepted
//   usedw_o        words currently held
//   almost_full_o  usedw_o >= ALMOST_FULL
//   almost_empty_o usedw_o <= ALMOST_EMPTY
//   busy_o         sort in progress
module sort_fifo #(
   parameter int DWIDTH       = 32,
   parameter int AWIDTH       = 4,
   parameter int DESCENDING   = 0,
   parameter int ALMOST_FULL  = 12,
   parameter int ALMOST_EMPTY = 2
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              wrreq_i,
   input  logic              eop_i,
   input  logic              rdreq_i,
   output logic [DWIDTH-1:0] q_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [AWIDTH:0]   usedw_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic              busy_o
);

   localparam int N = 1 << AWIDTH;
   localparam logic [AWIDTH:0]   N_W     = (AWIDTH+1)'(N);
   localparam logic [AWIDTH:0]   NM1_W   = (AWIDTH+1)'(N-1);
   localparam logic [AWIDTH:0]   ONE_W   = (AWIDTH+1)'(1);
   localparam logic [AWIDTH-1:0] LAST_PH = AWIDTH'(N-1);
   localparam logic [AWIDTH-1:0] PH_ONE  = AWIDTH'(1);

   typedef enum logic [1:0] {FILL, SORT, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [AWIDTH:0]   usedw_q, usedw_d;
   logic [AWIDTH-1:0] phase_q, phase_d;
   logic [DWIDTH-1:0] q_q;
   logic [DWIDTH-1:0] mem_q [N];
   logic [DWIDTH-1:0] mem_d [N];
   logic              wr_acc;
   logic              rd_acc;
   logic              head_vld;

   // True when the pair (lo at lower index, hi at higher index) must swap so
   // that index 0 ends up holding the head word.
   function automatic logic out_of_order(input logic [DWIDTH-1:0] lo,
                                         input logic [DWIDTH-1:0] hi);
      if (DESCENDING != 0) return lo < hi;
      else                 return lo > hi;
   endfunction

   assign wr_acc   = (state_q == FILL)  && wrreq_i && (usedw_q != N_W);
   assign rd_acc   = (state_q == DRAIN) && rdreq_i && (usedw_q != '0);
   assign head_vld = (state_q == DRAIN) && (usedw_q != '0);

   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         state_q <= FILL;
         usedw_q <= '0;
         phase_q <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         usedw_q <= usedw_d;
         phase_q <= phase_d;
         // Remember the word on display so q_o can hold it once empty.
         if (head_vld) q_q <= mem_q[0];
      end
   end

   // Storage is data only; a reset empties the FIFO via usedw_q instead.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   always_comb begin
      state_d = state_q;
      usedw_d = usedw_q;
      phase_d = '0;
      case (state_q)
         FILL: begin
            if (wr_acc) usedw_d = usedw_q + ONE_W;
            // Close the batch on eop with a write, a bare eop with data held,
            // or a write that fills the last slot.
            if ((wr_acc && (eop_i || (usedw_q == NM1_W))) ||
                (eop_i && !wrreq_i && (usedw_q != '0)))
               state_d = SORT;
         end
         SORT: begin
            phase_d = phase_q + PH_ONE;
            if (phase_q == LAST_PH) state_d = DRAIN;
         end
         DRAIN: begin
            if (rd_acc) usedw_d = usedw_q - ONE_W;
            if (usedw_q == '0) state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      case (state_q)
         FILL: begin
            if (wr_acc) mem_d[usedw_q[AWIDTH-1:0]] = data_i;
         end
         SORT: begin
            // Even phases touch pairs (0,1),(2,3)...; odd phases (1,2),(3,4)...
            // Slots at or beyond usedw_q hold stale data and are left alone.
            for (int i = 0; i < N-1; i++) begin
               if ((i[0] == phase_q[0]) && (usedw_q > (AWIDTH+1)'(i+1)) &&
                   out_of_order(mem_q[i], mem_q[i+1])) begin
                  mem_d[i]   = mem_q[i+1];
                  mem_d[i+1] = mem_q[i];
               end
            end
         end
         DRAIN: begin
            // Sorted order is preserved by shifting toward the head.
            if (rd_acc) begin
               for (int i = 0; i < N-1; i++) mem_d[i] = mem_q[i+1];
            end
         end
         default: ;
      endcase
   end

   assign q_o            = head_vld ? mem_q[0] : q_q;
   assign usedw_o        = usedw_q;
   assign busy_o         = (state_q == SORT);
   assign full_o         = (state_q != FILL) || (usedw_q == N_W);
   assign empty_o        = !head_vld;
   assign almost_full_o  = (int'(usedw_q) >= ALMOST_FULL);
   assign almost_empty_o = (int'(usedw_q) <= ALMOST_EMPTY);

endmodule
